// File: rtl/div_seq_param.sv
// Multi-cycle radix-2 restoring divider: quotient and remainder, signed or unsigned per operation,
// valid/ready on both sides, divide-by-zero and signed-overflow reported as flags.
module div_seq_param #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  signed_op,
  input  logic [DIVIDEND_W-1:0] A,
  input  logic [DIVISOR_W-1:0]  B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] result,
  output logic [DIVIDEND_W-1:0] odd,
  output logic                  div_zero,
  output logic                  ovf
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_reg, state_next;

  logic [DIVIDEND_W-1:0] dvd_reg;
  logic [DIVISOR_W-1:0]  rem_reg;
  logic [DIVISOR_W-1:0]  dsr_reg;
  logic                  qneg_reg, rneg_reg;
  logic [CNT_W-1:0]      cnt_reg;

  logic                  accept, b_zero, is_ovf, a_neg, b_neg, last;
  logic [DIVIDEND_W-1:0] a_mag;
  logic [DIVISOR_W-1:0]  b_mag;
  logic [DIVISOR_W:0]    shifted;
  logic                  ge;
  logic [DIVISOR_W-1:0]  diff, rem_new;
  logic [DIVIDEND_W-1:0] quo_step, rem_ext, quo_final, rem_final;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign accept    = in_valid && in_ready;

  assign b_zero = (B == '0);
  assign is_ovf = signed_op && A[DIVIDEND_W-1] && (A[DIVIDEND_W-2:0] == '0) && (B == '1);
  assign a_neg  = signed_op && A[DIVIDEND_W-1];
  assign b_neg  = signed_op && B[DIVISOR_W-1];
  assign a_mag  = a_neg ? -A : A;
  assign b_mag  = b_neg ? -B : B;
  assign last   = (cnt_reg == CNT_W'(DIVIDEND_W - 1));

  // The remainder is always below the divisor magnitude, so when the trial subtraction succeeds
  // the difference fits in DIVISOR_W bits and the modular low-bit subtraction is exact.
  assign shifted  = {rem_reg, dvd_reg[DIVIDEND_W-1]};
  assign ge       = (shifted >= {1'b0, dsr_reg});
  assign diff     = shifted[DIVISOR_W-1:0] - dsr_reg;
  assign rem_new  = ge ? diff : shifted[DIVISOR_W-1:0];
  assign quo_step = {dvd_reg[DIVIDEND_W-2:0], ge};

  always_comb begin
    rem_ext = '0;
    rem_ext[DIVISOR_W-1:0] = rem_new;
  end

  assign quo_final = qneg_reg ? -quo_step : quo_step;
  assign rem_final = rneg_reg ? -rem_ext : rem_ext;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = (b_zero || is_ovf) ? DONE : CALC;
      CALC:    if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_reg  <= '0;
      rem_reg  <= '0;
      dsr_reg  <= '0;
      qneg_reg <= 1'b0;
      rneg_reg <= 1'b0;
      cnt_reg  <= '0;
      result   <= '0;
      odd      <= '0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (b_zero) begin
              result   <= '1;
              odd      <= A;
              div_zero <= 1'b1;
              ovf      <= 1'b0;
            end else if (is_ovf) begin
              result   <= A;
              odd      <= '0;
              div_zero <= 1'b0;
              ovf      <= 1'b1;
            end else begin
              dvd_reg  <= a_mag;
              dsr_reg  <= b_mag;
              rem_reg  <= '0;
              qneg_reg <= a_neg ^ b_neg;
              rneg_reg <= a_neg;
              cnt_reg  <= '0;
            end
          end
        end
        CALC: begin
          dvd_reg <= quo_step;
          rem_reg <= rem_new;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (last) begin
            result   <= quo_final;
            odd      <= rem_final;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_param.sv
// Scoreboard bench for div_seq_param: directed cases, backpressure, mid-operation reset,
// and a randomised run against a golden model built on Verilog / and %.
module tb_div_seq_param;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, signed_op, out_valid, out_ready, div_zero, ovf;
  logic [31:0] A, result, odd;
  logic [15:0] B;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] odd;
    logic        dz;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  div_seq_param #(.DIVIDEND_W(32), .DIVISOR_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .signed_op(signed_op),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .result(result), .odd(odd),
    .div_zero(div_zero), .ovf(ovf)
  );

  function automatic exp_t golden(input logic [31:0] a, input logic [15:0] b, input logic s);
    exp_t e;
    int   sa, sb;
    e = '0;
    if (b == 16'h0) begin
      e.res = 32'hFFFF_FFFF;
      e.odd = a;
      e.dz  = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 16'hFFFF) begin
      e.res = a;
      e.ovf = 1'b1;
    end else if (s) begin
      sa    = a;
      sb    = $signed(b);
      e.res = 32'(sa / sb);
      e.odd = 32'(sa % sb);
    end else begin
      e.res = a / {16'h0, b};
      e.odd = a % {16'h0, b};
    end
    return e;
  endfunction

  // Drive one operation, returning #1 after its accept edge.
  task automatic send(input logic [31:0] a, input logic [15:0] b, input logic s);
    int guard = 0;
    A = a; B = b; signed_op = s; in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb_q.push_back(golden(a, b, s));
  endtask

  // Counts clock edges after the accept edge until out_valid is seen.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; signed_op = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, result, odd, div_zero, ovf} !== {1'b1, 1'b0, 64'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b res=%h odd=%h dz=%b ovf=%b, want rdy=1 vld=0 all zero",
               in_ready, out_valid, result, odd, div_zero, ovf);
    end
    $display("reset: rdy=%b vld=%b", in_ready, out_valid);
  endtask

  task automatic test_directed(input string name, input logic [31:0] a, input logic [15:0] b,
                               input logic s, input int lat);
    int   cyc;
    exp_t e;
    send(a, b, s);
    wait_valid(cyc);
    e = sb_q.pop_front();
    n_checks++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL %s timeout: out_valid not seen within %0d cycles", name, cyc);
    end
    n_checks++;
    if ({result, odd, div_zero, ovf} !== e) begin
      n_fail++;
      $display("FAIL %s value: got res=%h odd=%h dz=%b ovf=%b, want res=%h odd=%h dz=%b ovf=%b",
               name, result, odd, div_zero, ovf, e.res, e.odd, e.dz, e.ovf);
    end
    n_checks++;
    if (cyc !== lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d, want %0d", name, cyc, lat);
    end
    $display("%s: a=%h b=%h s=%b -> res=%h odd=%h dz=%b ovf=%b lat=%0d",
             name, a, b, s, result, odd, div_zero, ovf, cyc);
    ack();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release: got vld=%b rdy=%b, want vld=0 rdy=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_unsigned();
    test_directed("u_100_7", 32'd100, 16'd7, 1'b0, 32);
    test_directed("u_max", 32'hFFFF_FFFF, 16'hFFFF, 1'b0, 32);
    test_directed("u_fff9_2", 32'hFFFF_FFF9, 16'd2, 1'b0, 32);
  endtask

  task automatic test_div_zero();
    test_directed("div_zero", 32'h1234_5678, 16'h0, 1'b0, 0);
    test_directed("div_zero_s", 32'h8000_0000, 16'h0, 1'b1, 0);
  endtask

  task automatic test_signed();
    test_directed("s_m7_2", 32'hFFFF_FFF9, 16'd2, 1'b1, 32);
    test_directed("s_7_m2", 32'd7, 16'hFFFE, 1'b1, 32);
    test_directed("s_min_min", 32'h8000_0000, 16'h8000, 1'b1, 32);
  endtask

  task automatic test_overflow();
    test_directed("ovf", 32'h8000_0000, 16'hFFFF, 1'b1, 0);
    test_directed("no_ovf_unsigned", 32'h8000_0000, 16'hFFFF, 1'b0, 32);
  endtask

  task automatic test_backpressure_reset();
    int          cyc;
    exp_t        e;
    logic [65:0] snap;
    send(32'd1000, 16'd3, 1'b0);
    wait_valid(cyc);
    e = sb_q.pop_front();
    snap = {result, odd, div_zero, ovf};
    n_checks++;
    if (!out_valid || snap !== e) begin
      n_fail++;
      $display("FAIL bp_value: got vld=%b res=%h odd=%h, want vld=1 res=%h odd=%h",
               out_valid, result, odd, e.res, e.odd);
    end
    repeat (10) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {result, odd, div_zero, ovf} !== snap) begin
        n_fail++;
        $display("FAIL bp_hold: got vld=%b rdy=%b res=%h odd=%h, want vld=1 rdy=0 res=%h odd=%h",
                 out_valid, in_ready, result, odd, snap[65:34], snap[33:2]);
      end
    end
    $display("bp: held res=%h odd=%h for 10 cycles", result, odd);
    ack();

    send(32'd100, 16'd7, 1'b0);
    void'(sb_q.pop_back());
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_reset: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
    end
    repeat (40) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_ghost: got vld=%b after aborted op, want 0", out_valid);
      end
    end
    $display("abort: rdy=%b vld=%b", in_ready, out_valid);
    test_directed("after_abort", 32'd100, 16'd7, 1'b0, 32);
  endtask

  task automatic test_random();
    int          cyc, n_got;
    exp_t        e;
    logic [31:0] a;
    logic [15:0] b;
    logic        s;
    n_got = 0;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(8, 28);
      b = 16'($urandom_range(1, 16'hFFFF));
      if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 20));
      s = 1'($urandom_range(0, 1));
      send(a, b, s);
      wait_valid(cyc);
      n_checks++;
      if (!out_valid) begin
        n_fail++;
        $display("FAIL rnd_timeout: op %0d out_valid not seen", i);
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      e = sb_q.pop_front();
      n_checks++;
      if ({result, odd, div_zero, ovf} !== e) begin
        n_fail++;
        $display("FAIL rnd_value: op %0d a=%h b=%h s=%b got res=%h odd=%h, want res=%h odd=%h",
                 i, a, b, s, result, odd, e.res, e.odd);
      end
      $display("rnd %0d: a=%h b=%h s=%b -> res=%h odd=%h", i, a, b, s, result, odd);
      ack();
      n_got++;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_dup: op %0d out_valid still high after accept", i);
      end
    end
    n_checks++;
    if (n_got !== 1000 || sb_q.size() !== 0) begin
      n_fail++;
      $display("FAIL rnd_count: got %0d results with %0d pending, want 1000 and 0", n_got, sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_div_zero();
    test_signed();
    test_overflow();
    test_backpressure_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
